// File: rtl/decode.sv
// RV32I decode stage: register file, control decoder, immediate extender and flushable D/E register.
// Optional same-cycle write-through on register reads is enabled by defining REGFILE_BYPASS_EN.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] inc_PCD,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        JalrE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic        ALUSrcAE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  Funct3E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] inc_PCE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] a0
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic        alu_src;
    logic        alu_src_a;
    logic [1:0]  result_src;
    logic [3:0]  alu_ctrl;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] inc_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } de_t;

  // Shared ALU-op mapping for R-type and I-ALU; only R-type may select sub.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7b5) ? 4'b0001 : 4'b0000;
      3'b001:  alu_dec = 4'b0111;
      3'b010:  alu_dec = 4'b0101;
      3'b011:  alu_dec = 4'b0110;
      3'b100:  alu_dec = 4'b0100;
      3'b101:  alu_dec = f7b5 ? 4'b1001 : 4'b1000;
      3'b110:  alu_dec = 4'b0011;
      3'b111:  alu_dec = 4'b0010;
      default: alu_dec = 4'b0000;
    endcase
  endfunction

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        rf_we_s;
  logic [31:0] rd1_s, rd2_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  de_t         dec_s, de_d, de_q;

  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];
  assign opcode_s = InstrD[6:0];
  assign funct3_s = InstrD[14:12];
  assign rf_we_s  = rst && RegWriteW && (RdW != 5'd0);
  assign a0       = regs_q[10];

  assign imm_i_s = {{20{InstrD[31]}}, InstrD[31:20]};
  assign imm_s_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b_s = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_u_s = {InstrD[31:12], 12'd0};
  assign imm_j_s = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = (rf_we_s && (RdW == 5'(i))) ? ResultW : regs_q[i];
    end
  end

  always_comb begin
    rd1_s = 32'd0;
    rd2_s = 32'd0;
    if (Rs1D == 5'd0) begin
      rd1_s = 32'd0;
`ifdef REGFILE_BYPASS_EN
    end else if (rf_we_s && (RdW == Rs1D)) begin
      rd1_s = ResultW;
`endif
    end else begin
      rd1_s = regs_q[Rs1D];
    end
    if (Rs2D == 5'd0) begin
      rd2_s = 32'd0;
`ifdef REGFILE_BYPASS_EN
    end else if (rf_we_s && (RdW == Rs2D)) begin
      rd2_s = ResultW;
`endif
    end else begin
      rd2_s = regs_q[Rs2D];
    end
  end

  // Unrecognised opcodes leave every control (including funct3) at zero.
  always_comb begin
    dec_s        = '0;
    dec_s.rd1    = rd1_s;
    dec_s.rd2    = rd2_s;
    dec_s.pc     = PCD;
    dec_s.inc_pc = inc_PCD;
    dec_s.rs1    = Rs1D;
    dec_s.rs2    = Rs2D;
    dec_s.rd     = InstrD[11:7];
    dec_s.funct3 = funct3_s;
    case (opcode_s)
      OP_R: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_ctrl  = alu_dec(funct3_s, InstrD[30], 1'b1);
      end
      OP_I: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.alu_ctrl  = alu_dec(funct3_s, InstrD[30], 1'b0);
        dec_s.imm       = imm_i_s;
      end
      OP_LOAD: begin
        dec_s.reg_write  = 1'b1;
        dec_s.alu_src    = 1'b1;
        dec_s.result_src = 2'b01;
        dec_s.imm        = imm_i_s;
      end
      OP_STORE: begin
        dec_s.mem_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.imm       = imm_s_s;
      end
      OP_BRANCH: begin
        dec_s.branch   = 1'b1;
        dec_s.alu_ctrl = 4'b0001;
        dec_s.imm      = imm_b_s;
      end
      OP_JAL: begin
        dec_s.jump       = 1'b1;
        dec_s.reg_write  = 1'b1;
        dec_s.result_src = 2'b10;
        dec_s.imm        = imm_j_s;
      end
      OP_JALR: begin
        dec_s.jump       = 1'b1;
        dec_s.jalr       = 1'b1;
        dec_s.reg_write  = 1'b1;
        dec_s.alu_src    = 1'b1;
        dec_s.result_src = 2'b10;
        dec_s.imm        = imm_i_s;
      end
      OP_LUI: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.alu_ctrl  = 4'b1010;
        dec_s.imm       = imm_u_s;
      end
      OP_AUIPC: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.alu_src_a = 1'b1;
        dec_s.imm       = imm_u_s;
      end
      default: begin
        dec_s.funct3 = 3'b000;
      end
    endcase
  end

  always_comb begin
    if (FlushE) begin
      de_d = '0;
    end else begin
      de_d = dec_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      de_q <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      de_q   <= de_d;
      regs_q <= regs_d;
    end
  end

  assign RegWriteE   = de_q.reg_write;
  assign MemWriteE   = de_q.mem_write;
  assign JumpE       = de_q.jump;
  assign JalrE       = de_q.jalr;
  assign BranchE     = de_q.branch;
  assign ALUSrcE     = de_q.alu_src;
  assign ALUSrcAE    = de_q.alu_src_a;
  assign ResultSrcE  = de_q.result_src;
  assign ALUControlE = de_q.alu_ctrl;
  assign Funct3E     = de_q.funct3;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ImmExtE     = de_q.imm;
  assign PCE         = de_q.pc;
  assign inc_PCE     = de_q.inc_pc;
  assign Rs1E        = de_q.rs1;
  assign Rs2E        = de_q.rs2;
  assign RdE         = de_q.rd;

endmodule

// File: tb/tb_decode.sv
// Directed scoreboard bench for decode; expected E-stage values are queued per driven cycle.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_decode;
  logic        clk = 1'b0;
  logic        rst, FlushE, RegWriteW;
  logic [31:0] InstrD, PCD, inc_PCD, ResultW;
  logic [4:0]  RdW, Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, ALUSrcAE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, inc_PCE, a0;

  decode dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .inc_PCD(inc_PCD), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .inc_PCE(inc_PCE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .a0(a0)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'd9;
`else
  localparam logic [31:0] BYP_EXP = 32'd7;
`endif

  typedef struct {
    string       tag;
    logic [6:0]  ctrl;
    logic [1:0]  rsrc;
    logic [3:0]  aluc;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm, pc, ipc, a0;
    logic [4:0]  rs1, rs2, rd;
    logic [12:0] care;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_v = 32'h0000_0100;
  logic [31:0] last_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_exp(input string tag);
    cur.tag  = tag;
    cur.care = 13'd0;
  endtask

  task automatic want_ctrl(input logic [6:0] c, input logic [1:0] r, input logic [3:0] a, input logic [2:0] f);
    cur.ctrl = c; cur.rsrc = r; cur.aluc = a; cur.f3 = f;
    cur.care[3:0] = 4'hF;
  endtask

  task automatic want_rd(input logic [31:0] r1, input logic [31:0] r2);
    cur.rd1 = r1; cur.rd2 = r2; cur.care[5:4] = 2'b11;
  endtask

  task automatic want_imm(input logic [31:0] v);
    cur.imm = v; cur.care[6] = 1'b1;
  endtask

  task automatic want_pc(input logic [31:0] p, input logic [31:0] ip);
    cur.pc = p; cur.ipc = ip; cur.care[8:7] = 2'b11;
  endtask

  task automatic want_idx(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    cur.rs1 = r1; cur.rs2 = r2; cur.rd = d; cur.care[11:9] = 3'b111;
  endtask

  task automatic want_a0(input logic [31:0] v);
    cur.a0 = v; cur.care[12] = 1'b1;
  endtask

  task automatic want_zero();
    want_ctrl(7'd0, 2'd0, 4'd0, 3'd0);
    want_rd(32'd0, 32'd0);
    want_imm(32'd0);
    want_pc(32'd0, 32'd0);
    want_idx(5'd0, 5'd0, 5'd0);
  endtask

  task automatic push();
    sb.push_back(cur);
  endtask

  task automatic drive(input logic [31:0] instr);
    InstrD  = instr;
    PCD     = pc_v;
    inc_PCD = pc_v + 32'd4;
    last_pc = pc_v;
    pc_v    = pc_v + 32'd4;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] res);
    RegWriteW = we; RdW = rd; ResultW = res;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      if (e.care[0])  chk({e.tag, ".ctrl"}, {25'd0, RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, ALUSrcAE}, {25'd0, e.ctrl});
      if (e.care[1])  chk({e.tag, ".rsrc"}, {30'd0, ResultSrcE}, {30'd0, e.rsrc});
      if (e.care[2])  chk({e.tag, ".aluc"}, {28'd0, ALUControlE}, {28'd0, e.aluc});
      if (e.care[3])  chk({e.tag, ".f3"}, {29'd0, Funct3E}, {29'd0, e.f3});
      if (e.care[4])  chk({e.tag, ".rd1"}, RD1E, e.rd1);
      if (e.care[5])  chk({e.tag, ".rd2"}, RD2E, e.rd2);
      if (e.care[6])  chk({e.tag, ".imm"}, ImmExtE, e.imm);
      if (e.care[7])  chk({e.tag, ".pc"}, PCE, e.pc);
      if (e.care[8])  chk({e.tag, ".ipc"}, inc_PCE, e.ipc);
      if (e.care[9])  chk({e.tag, ".rs1"}, {27'd0, Rs1E}, {27'd0, e.rs1});
      if (e.care[10]) chk({e.tag, ".rs2"}, {27'd0, Rs2E}, {27'd0, e.rs2});
      if (e.care[11]) chk({e.tag, ".rd"}, {27'd0, RdE}, {27'd0, e.rd});
      if (e.care[12]) chk({e.tag, ".a0"}, a0, e.a0);
    end
  endtask

  initial begin
    rst = 1'b0; FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    drive(32'h0050_0093);

    // reset held two cycles, with a write attempt that must be suppressed
    new_exp("reset1"); want_zero(); want_a0(32'd0); push(); step();
    wb(1'b1, 5'd10, 32'h0000_0055);
    new_exp("reset2"); want_zero(); want_a0(32'd0); push(); step();

    rst = 1'b1; wb(1'b0, 5'd0, 32'd0);
    drive(32'h0050_0093);
    #1;
    chk("rs1d_addi", {27'd0, Rs1D}, 32'd0);
    chk("rs2d_addi", {27'd0, Rs2D}, 32'd5);
    new_exp("addi"); want_ctrl(7'b1000010, 2'b00, 4'b0000, 3'b000); want_rd(32'd0, 32'd0);
    want_imm(32'd5); want_pc(last_pc, last_pc + 32'd4); want_idx(5'd0, 5'd5, 5'd1); want_a0(32'd0);
    push(); step();

    drive(32'h0000_0013); wb(1'b1, 5'd10, 32'hDEAD_BEEF);
    new_exp("wb_a0"); want_a0(32'hDEAD_BEEF); push(); step();

    drive(32'h0000_0013); wb(1'b1, 5'd0, 32'h0000_1234);
    new_exp("wb_x0_same"); want_rd(32'd0, 32'd0); want_a0(32'hDEAD_BEEF); push(); step();
    drive(32'h0000_0013); wb(1'b0, 5'd0, 32'd0);
    new_exp("wb_x0_after"); want_rd(32'd0, 32'd0); push(); step();

    drive(32'h0000_0013); wb(1'b1, 5'd5, 32'd7);
    new_exp("wr_x5"); want_ctrl(7'b1000010, 2'b00, 4'b0000, 3'b000); push(); step();

    drive(32'h0052_8333); wb(1'b1, 5'd5, 32'd9);
    #1;
    chk("rs1d_add", {27'd0, Rs1D}, 32'd5);
    chk("rs2d_add", {27'd0, Rs2D}, 32'd5);
    new_exp("bypass"); want_ctrl(7'b1000000, 2'b00, 4'b0000, 3'b000); want_rd(BYP_EXP, BYP_EXP);
    want_idx(5'd5, 5'd5, 5'd6); push(); step();
    drive(32'h0052_8333); wb(1'b0, 5'd0, 32'd0);
    new_exp("post_bypass"); want_rd(32'd9, 32'd9); push(); step();

    // flush while a writeback to x11 proceeds
    drive(32'h00A1_2023); FlushE = 1'b1; wb(1'b1, 5'd11, 32'h0000_ABCD);
    new_exp("flush"); want_zero(); want_a0(32'hDEAD_BEEF); push(); step();
    drive(32'h00A1_2023); FlushE = 1'b0; wb(1'b0, 5'd0, 32'd0);
    new_exp("sw"); want_ctrl(7'b0100010, 2'b00, 4'b0000, 3'b010); want_imm(32'd0);
    want_idx(5'd2, 5'd10, 5'd0); want_rd(32'd0, 32'hDEAD_BEEF); want_pc(last_pc, last_pc + 32'd4);
    push(); step();

    drive(32'hFE00_0EE3);
    new_exp("beq"); want_ctrl(7'b0000100, 2'b00, 4'b0001, 3'b000); want_imm(32'hFFFF_FFFC); push(); step();

    drive(32'h0080_00EF);
    new_exp("jal"); want_ctrl(7'b1010000, 2'b10, 4'b0000, 3'b000); want_imm(32'd8);
    want_idx(5'd0, 5'd8, 5'd1); push(); step();

    drive(32'hFFFF_FFFF);
    new_exp("illegal"); want_ctrl(7'd0, 2'd0, 4'd0, 3'd0); push(); step();

    drive(32'h1234_51B7);
    new_exp("lui"); want_ctrl(7'b1000010, 2'b00, 4'b1010, 3'b101); want_imm(32'h1234_5000); push(); step();

    drive(32'h0000_1217);
    new_exp("auipc"); want_ctrl(7'b1000011, 2'b00, 4'b0000, 3'b001); want_imm(32'h0000_1000);
    want_pc(last_pc, last_pc + 32'd4); push(); step();

    drive(32'h0005_8633);
    new_exp("flush_wb_x11"); want_rd(32'h0000_ABCD, 32'd0); want_idx(5'd11, 5'd0, 5'd12); push(); step();

    drive(32'h4031_5093);
    new_exp("srai"); want_ctrl(7'b1000010, 2'b00, 4'b1001, 3'b101); want_imm(32'h0000_0403); push(); step();

    drive(32'h4000_0093);
    new_exp("addi_b30"); want_ctrl(7'b1000010, 2'b00, 4'b0000, 3'b000); want_imm(32'h0000_0400); push(); step();

    // reset mid-operation with a pending writeback
    rst = 1'b0; drive(32'h0052_8333); wb(1'b1, 5'd10, 32'h1111_1111);
    new_exp("mid_reset"); want_zero(); want_a0(32'd0); push(); step();
    rst = 1'b1; wb(1'b0, 5'd0, 32'd0); drive(32'h0052_8333);
    new_exp("after_reset"); want_ctrl(7'b1000000, 2'b00, 4'b0000, 3'b000); want_rd(32'd0, 32'd0);
    want_a0(32'd0); push(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
